// File: rtl/conv_pkg.sv
// Shared widths, FIFO entry layout and saturation helpers for the conv output stage.
`timescale 1ns/1ps
package conv_pkg;

  localparam int unsigned DEFAULT_ACC_SIZE  = 18;
  localparam int unsigned DEFAULT_OUT_WIDTH = 8;

  // Largest value representable in a w-bit signed number.
  function automatic int sat_hi(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Smallest value representable in a w-bit signed number.
  function automatic int sat_lo(input int unsigned w);
    return -(1 << (w - 1));
  endfunction

  localparam int SAT_MAX = sat_hi(DEFAULT_OUT_WIDTH);
  localparam int SAT_MIN = sat_lo(DEFAULT_OUT_WIDTH);

  // One buffered output sample at the default output width.
  typedef struct packed {
    logic signed [DEFAULT_OUT_WIDTH-1:0] data;
    logic                                last;
  } fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with valid/ready on both sides.
// Ready and valid are derived from the registered occupancy count only.
`timescale 1ns/1ps
module sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  assign wr_ready = (count < CW'(DEPTH));
  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];

  // Handshakes gated by registered status, so overflow/underflow cannot occur.
  assign push = wr_valid & wr_ready;
  assign pop  = rd_valid & rd_ready;

  // Pointer and occupancy tracking; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents are left untouched by reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/conv_out_requant.sv
// Convolution output requantizer: round-half-up arithmetic shift, optional
// ReLU clamp, signed saturation, frame-end tagging and a small output FIFO.
// Optional feature: define CONV_OUT_RELU_EN to clamp negative results to 0.
`timescale 1ns/1ps
module conv_out_requant #(
  parameter int unsigned ACC_SIZE       = conv_pkg::DEFAULT_ACC_SIZE,
  parameter int unsigned OUT_WIDTH      = conv_pkg::DEFAULT_OUT_WIDTH,
  parameter int unsigned SHIFT          = 4,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned OUTS_PER_FRAME = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_valid_y,
  output logic                        s_ready_y,
  input  logic signed [ACC_SIZE-1:0]  s_data_in_y,
  output logic                        m_valid_z,
  input  logic                        m_ready_z,
  output logic signed [OUT_WIDTH-1:0] m_data_out_z,
  output logic                        m_last_z,
  output logic                        sat_flag
);

  import conv_pkg::*;

  // One guard bit so the rounding add can never overflow.
  localparam int unsigned RW   = ACC_SIZE + 1;
  localparam int unsigned FC_W = (OUTS_PER_FRAME > 1) ? $clog2(OUTS_PER_FRAME) : 1;

  localparam logic [FC_W-1:0]      FC_LAST = FC_W'(OUTS_PER_FRAME - 1);
  localparam logic signed [RW-1:0] SAT_HI  = RW'(sat_hi(OUT_WIDTH));
  localparam logic signed [RW-1:0] SAT_LO  = RW'(sat_lo(OUT_WIDTH));

  // Same layout as conv_pkg::fifo_entry_t, sized by this instance's OUT_WIDTH.
  typedef struct packed {
    logic signed [OUT_WIDTH-1:0] data;
    logic                        last;
  } entry_t;

  logic signed [RW-1:0]        ext_c;
  logic signed [RW-1:0]        rounded_c;
  logic signed [RW-1:0]        clamped_c;
  logic signed [OUT_WIDTH-1:0] q_c;
  logic                        sat_c;
  logic                        accept;
  logic [FC_W-1:0]             frame_cnt;
  entry_t                      wr_entry;
  entry_t                      rd_entry;

  assign ext_c  = RW'(s_data_in_y);
  assign accept = s_valid_y & s_ready_y;

  // Round half up by adding half an LSB of the result before the arithmetic shift.
  if (SHIFT > 0) begin : g_round
    localparam logic signed [RW-1:0] HALF = RW'(1 << (SHIFT - 1));
    assign rounded_c = (ext_c + HALF) >>> SHIFT;
  end else begin : g_pass
    assign rounded_c = ext_c;
  end

  // Optional rectification ahead of saturation.
  always_comb begin
`ifdef CONV_OUT_RELU_EN
    clamped_c = rounded_c[RW-1] ? '0 : rounded_c;
`else
    clamped_c = rounded_c;
`endif
  end

  // Clip into the signed output range and report whether clipping happened.
  always_comb begin
    q_c   = clamped_c[OUT_WIDTH-1:0];
    sat_c = 1'b0;
    if (clamped_c > SAT_HI) begin
      q_c   = SAT_HI[OUT_WIDTH-1:0];
      sat_c = 1'b1;
    end else if (clamped_c < SAT_LO) begin
      q_c   = SAT_LO[OUT_WIDTH-1:0];
      sat_c = 1'b1;
    end
  end

  // Entry written on the accepting edge; last marks the final output of a frame.
  always_comb begin
    wr_entry      = '0;
    wr_entry.data = q_c;
    wr_entry.last = (frame_cnt == FC_LAST);
  end

  // Position of the next accepted sample within its frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (accept) begin
      frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + FC_W'(1);
    end
  end

  // Sticky record of any clipped sample since reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sat_flag <= 1'b0;
    end else if (accept && sat_c) begin
      sat_flag <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (s_valid_y),
    .wr_ready (s_ready_y),
    .wr_data  (wr_entry),
    .rd_valid (m_valid_z),
    .rd_ready (m_ready_z),
    .rd_data  (rd_entry)
  );

  assign m_data_out_z = rd_entry.data;
  assign m_last_z     = rd_entry.last;

endmodule

// File: tb/tb_conv_out_requant.sv
// Self-checking bench for conv_out_requant with default parameters.
`timescale 1ns/1ps
module tb_conv_out_requant;

  localparam int SH  = 4;
  localparam int OPF = 5;

  logic              clk;
  logic              reset;
  logic              s_valid_y;
  logic              s_ready_y;
  logic signed [17:0] s_data_in_y;
  logic              m_valid_z;
  logic              m_ready_z;
  logic signed [7:0] m_data_out_z;
  logic              m_last_z;
  logic              sat_flag;

  conv_out_requant dut (
    .clk          (clk),
    .reset        (reset),
    .s_valid_y    (s_valid_y),
    .s_ready_y    (s_ready_y),
    .s_data_in_y  (s_data_in_y),
    .m_valid_z    (m_valid_z),
    .m_ready_z    (m_ready_z),
    .m_data_out_z (m_data_out_z),
    .m_last_z     (m_last_z),
    .sat_flag     (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int pops   = 0;
  int fc     = 0;
  bit lat_chk = 1'b0;

  typedef struct {
    int data;
    bit last;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   last_pos[$];

  typedef struct {
    int din;
    int exp;
    bit sat;
  } vec_t;

  vec_t tbl[16];

  always @(posedge clk) cycle <= cycle + 1;

  function automatic void model(input int x, output int y, output bit s);
    int r;
    r = (x + (1 << (SH - 1))) >>> SH;
`ifdef CONV_OUT_RELU_EN
    if (r < 0) r = 0;
`endif
    s = 1'b0;
    if (r > 127) begin
      r = 127;
      s = 1'b1;
    end else if (r < -128) begin
      r = -128;
      s = 1'b1;
    end
    y = r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expectations enter on input handshake, leave on output handshake.
  always @(negedge clk) begin
    exp_t e;
    int   y;
    bit   s;
    if (!reset) begin
      if (m_valid_z && m_ready_z) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got data %0d with no expected entry", int'(m_data_out_z));
        end else begin
          e = sb.pop_front();
          check("sb_data", int'(m_data_out_z), e.data);
          check("sb_last", int'(m_last_z), int'(e.last));
          if (lat_chk) check("latency", cycle - e.cyc, 1);
          pops++;
          if (m_last_z) last_pos.push_back(pops);
        end
      end
      if (s_valid_y && s_ready_y) begin
        model(int'(s_data_in_y), y, s);
        e.data = y;
        e.last = (fc == OPF - 1);
        e.cyc  = cycle;
        sb.push_back(e);
        fc = (fc == OPF - 1) ? 0 : fc + 1;
      end
    end
  end

  // Present one sample and hold it until accepted; leaves s_valid_y asserted.
  task automatic send(input int v);
    int n;
    n = 0;
    s_valid_y   = 1'b1;
    s_data_in_y = 18'(v);
    while (1) begin
      @(negedge clk);
      if (s_ready_y) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got s_ready_y=0 for %0d cycles expected acceptance", n);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    fc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_d;
    bit exp_s;
    bit sat_sticky;

    // ReLU-off expectations; adjusted below when ReLU is built in.
    tbl[0]  = '{100,      6,    1'b0};
    tbl[1]  = '{-24,     -1,    1'b0};
    tbl[2]  = '{0,        0,    1'b0};
    tbl[3]  = '{7,        0,    1'b0};
    tbl[4]  = '{8,        1,    1'b0};
    tbl[5]  = '{-8,       0,    1'b0};
    tbl[6]  = '{-9,      -1,    1'b0};
    tbl[7]  = '{2039,     127,  1'b0};
    tbl[8]  = '{-2056,   -128,  1'b0};
    tbl[9]  = '{2040,     127,  1'b1};
    tbl[10] = '{40000,    127,  1'b1};
    tbl[11] = '{-3000,   -128,  1'b1};
    tbl[12] = '{-2057,   -128,  1'b1};
    tbl[13] = '{131071,   127,  1'b1};
    tbl[14] = '{-131072, -128,  1'b1};
    tbl[15] = '{-1,       0,    1'b0};

    reset       = 1'b1;
    s_valid_y   = 1'b0;
    s_data_in_y = '0;
    m_ready_z   = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_m_valid", int'(m_valid_z), 0);
    check("rst_s_ready", int'(s_ready_y), 1);
    check("rst_m_last",  int'(m_last_z),  0);
    check("rst_sat",     int'(sat_flag),  0);

    // Rounding and saturation vectors, one at a time into an empty FIFO.
    @(posedge clk);
    #1 m_ready_z = 1'b1;
    sat_sticky = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_d = tbl[i].exp;
      exp_s = tbl[i].sat;
`ifdef CONV_OUT_RELU_EN
      if (exp_d < 0) begin
        exp_d = 0;
        exp_s = 1'b0;
      end
`endif
      sat_sticky |= exp_s;
      send(tbl[i].din);
      s_valid_y = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), int'(m_valid_z), 1);
      check($sformatf("vec%0d_data", i), int'(m_data_out_z), exp_d);
      check($sformatf("vec%0d_sat", i), int'(sat_flag), int'(sat_sticky));
    end

    // Backpressure: fill, stall, reject a fifth sample, then drain in order.
    @(posedge clk);
    #1 m_ready_z = 1'b0;
    pops = 0;
    send(160);
    send(-320);
    send(48);
    send(1000);
    s_valid_y   = 1'b1;
    s_data_in_y = 18'(500);
    @(negedge clk);
    check("bp_full_ready", int'(s_ready_y), 0);
    check("bp_full_valid", int'(m_valid_z), 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_stall_ready", int'(s_ready_y), 0);
      if (sb.size() > 0) begin
        check("bp_stall_data", int'(m_data_out_z), sb[0].data);
        check("bp_stall_last", int'(m_last_z), int'(sb[0].last));
      end
    end
    @(posedge clk);
    #1 s_valid_y = 1'b0;
    m_ready_z = 1'b1;
    repeat (8) @(negedge clk);
    check("bp_pops", pops, 4);
    check("bp_empty", int'(m_valid_z), 0);
    check("bp_sb_left", sb.size(), 0);

    // Framing: ten back-to-back samples from a fresh frame.
    pulse_reset();
    @(negedge clk);
    check("frm_rst_sat", int'(sat_flag), 0);
    @(posedge clk);
    #1;
    pops = 0;
    last_pos.delete();
    lat_chk = 1'b1;
    for (int i = 0; i < 10; i++) send(i * 37 - 100);
    s_valid_y = 1'b0;
    repeat (3) @(negedge clk);
    lat_chk = 1'b0;
    check("frm_pops", pops, 10);
    check("frm_last_count", last_pos.size(), 2);
    if (last_pos.size() >= 2) begin
      check("frm_last_pos0", last_pos[0], 5);
      check("frm_last_pos1", last_pos[1], 10);
    end

    // Reset mid-operation with entries buffered and a saturation recorded.
    @(posedge clk);
    #1 m_ready_z = 1'b0;
    send(40000);
    send(16);
    send(32);
    s_valid_y = 1'b0;
    @(negedge clk);
    check("mid_valid_before", int'(m_valid_z), 1);
    check("mid_sat_before", int'(sat_flag), 1);
    pulse_reset();
    @(negedge clk);
    check("mid_rst_valid", int'(m_valid_z), 0);
    check("mid_rst_ready", int'(s_ready_y), 1);
    check("mid_rst_last",  int'(m_last_z),  0);
    check("mid_rst_sat",   int'(sat_flag),  0);
    @(posedge clk);
    #1 m_ready_z = 1'b1;
    pops = 0;
    last_pos.delete();
    for (int i = 0; i < 5; i++) send(i * 50);
    s_valid_y = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_pops", pops, 5);
    check("mid_last_count", last_pos.size(), 1);
    if (last_pos.size() >= 1) check("mid_last_pos", last_pos[0], 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
